axis_tx_sink: RTL and testbench
===============================

// Module: axis_tx_sink
// PURPOSE
// - Downstream consumer of the DUT's 64-bit AXIS TX port in the clk156 Ethernet sim environment.
// - Accepts frames, checks tkeep/tlast framing and frame length, and keeps frame/byte/error counters.
// - Records the length of the last frame and raises done after MAX_RECVPKT frames.
// - Optionally applies pseudo-random backpressure on tready.
// PARAMETERS
// - MAX_RECVPKT  10       frames accepted before done; tready then held low
// - MIN_FRAME    60       minimum legal frame length in bytes, inclusive
// - MAX_FRAME    1514     maximum legal frame length in bytes, inclusive
// - LFSR_SEED    16'hACE1 backpressure LFSR seed; must be non-zero
// PORTS
// - clk156          in   1   156.25 MHz clock; everything is synchronous to it
// - rst_n           in   1   reset, asynchronous assert, active-low
// - s_axis_tx_tvalid in  1   beat valid, from DUT m_axis_tx_tvalid
// - s_axis_tx_tdata in   64  beat data; byte 0 = [7:0]
// - s_axis_tx_tkeep in   8   byte enables
// - s_axis_tx_tlast in   1   last beat of frame
// - s_axis_tx_tuser in   1   on the last beat, 1 = frame marked bad by source
// - s_axis_tx_tready out 1   sink ready, to DUT m_axis_tx_tready
// - frame_cnt       out  32  good frames received
// - byte_cnt        out  32  bytes in good frames; wraps modulo 2^32
// - err_cnt         out  16  bad frames; saturates at 16'hFFFF
// - err_flags       out  4   sticky: [0] tkeep, [1] runt, [2] giant, [3] tuser
// - last_len        out  16  byte length of the most recently completed frame, good or bad
// - done            out  1   high once frame_cnt + err_cnt reaches MAX_RECVPKT
// BEHAVIOUR
// - Reset: all outputs 0 except s_axis_tx_tready = 1 (without the macro). FSM goes to IDLE.
//   The LFSR loads LFSR_SEED. Reset asserted mid-frame discards that frame; no counter is updated.
// - A beat transfers when s_axis_tx_tvalid && s_axis_tx_tready. Non-transfer cycles change no state.
// - FSM states:
//   - IDLE: a transferred beat goes to RECV, or stays in IDLE if it carries tlast (one-beat frame).
//   - RECV: a transferred beat with tlast goes back to IDLE.
//   - DONE: terminal; s_axis_tx_tready = 0. Left only by reset.
// - tkeep rules:
//   - A non-last beat must have tkeep == 8'hFF.
//   - A last beat must have tkeep in {01,03,07,0F,1F,3F,7F,FF}.
//   - A violation marks the frame bad and sets err_flags[0]. The frame is still consumed to tlast.
// - Length: len accumulates popcount(tkeep) per beat in 16 bits, saturating at 16'hFFFF.
// - Frame close, on the tlast beat:
//   - last_len = final len.
//   - Bad frame: len < MIN_FRAME sets flag[1]; len > MAX_FRAME sets flag[2]; tuser = 1 sets flag[3];
//     err_cnt += 1, saturating.
//   - Good frame: frame_cnt += 1 and byte_cnt += len.
//   - Counters update 1 cycle after the tlast beat (registered).
// - done and DONE: when frame_cnt + err_cnt == MAX_RECVPKT after an update, done rises in that same
//   registered cycle. The FSM enters DONE and tready drops that cycle. The upstream beat presented on
//   that cycle is not taken.
// - A tlast beat in IDLE is a complete 1-beat frame (normally a runt).
// - Simultaneous tkeep error + runt in one frame: both flags set, err_cnt += 1 only.
// CONFIGURATION
// - AXIS_TX_SINK_BACKPRESSURE_EN defined:
//   - 16-bit Fibonacci LFSR, taps 16,14,13,11, advances every cycle.
//   - Outside DONE, s_axis_tx_tready = lfsr[0] | lfsr[1], giving ~75% duty.
//   - Reset value of s_axis_tx_tready is LFSR_SEED[0] | LFSR_SEED[1].
// - Not defined: no LFSR is built; s_axis_tx_tready = 1 except in DONE.
// TESTING
// - 64B frame, 8 full beats, last tkeep FF, tuser 0 -> frame_cnt=1, byte_cnt=64, last_len=64, err_flags=0.
// - 61B frame, last tkeep 8'h1F -> last_len=61, frame_cnt+1; next case: last tkeep 8'h05 -> err_flags[0]=1, err_cnt=1.
// - Mid-frame beat tkeep 8'h7F -> err_flags[0]=1; frame still consumed to tlast; no tready stall.
// - 40B frame -> err_flags[1]=1, err_cnt=1. 1520B frame -> err_flags[2]=1. tuser=1 on a 64B frame -> err_flags[3]=1.
// - MAX_RECVPKT=3, send 4 back-to-back 64B frames -> done=1 one cycle after the 3rd tlast; tready=0; 4th frame not accepted.
// - Assert rst_n low mid-frame, then resend a 64B frame -> counters 0 after reset; frame_cnt=1, last_len=64.

Source files
------------

// File: rtl/axis_tx_sink.sv
// AXIS TX sink: checks tkeep/tlast framing and frame length, keeps frame/byte/error counters.
// Optional pseudo-random tready backpressure when AXIS_TX_SINK_BACKPRESSURE_EN is defined.
module axis_tx_sink #(
  parameter int unsigned MAX_RECVPKT = 10,
  parameter int unsigned MIN_FRAME   = 60,
  parameter int unsigned MAX_FRAME   = 1514,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic        clk156,
  input  logic        rst_n,
  input  logic        s_axis_tx_tvalid,
  input  logic [63:0] s_axis_tx_tdata,
  input  logic [7:0]  s_axis_tx_tkeep,
  input  logic        s_axis_tx_tlast,
  input  logic        s_axis_tx_tuser,
  output logic        s_axis_tx_tready,
  output logic [31:0] frame_cnt,
  output logic [31:0] byte_cnt,
  output logic [15:0] err_cnt,
  output logic [3:0]  err_flags,
  output logic [15:0] last_len,
  output logic        done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RECV = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [15:0] len_q, len_d;
  logic        kerr_q, kerr_d;
  logic [31:0] frame_cnt_q, frame_cnt_d;
  logic [31:0] byte_cnt_q, byte_cnt_d;
  logic [15:0] err_cnt_q, err_cnt_d;
  logic [3:0]  err_flags_q, err_flags_d;
  logic [15:0] last_len_q, last_len_d;
  logic        done_q, done_d;

  logic        bp_ready;
  logic        beat;
  logic [3:0]  pc;
  logic [16:0] len_sum;
  logic [15:0] len_new;
  logic        last_keep_ok;
  logic        keep_err;
  logic        frame_kerr;
  logic        runt;
  logic        giant;
  logic        bad;
  logic [32:0] total_d;

  // Payload content is not inspected; only framing is.
  logic unused_tdata;
  assign unused_tdata = ^s_axis_tx_tdata;

`ifdef AXIS_TX_SINK_BACKPRESSURE_EN
  logic [15:0] lfsr_q, lfsr_d;
  assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  always_ff @(posedge clk156 or negedge rst_n) begin
    if (!rst_n) lfsr_q <= LFSR_SEED;
    else        lfsr_q <= lfsr_d;
  end
  assign bp_ready = lfsr_q[0] | lfsr_q[1];
`else
  assign bp_ready = 1'b1;
`endif

  assign s_axis_tx_tready = bp_ready && (state_q != S_DONE);
  assign beat = s_axis_tx_tvalid && s_axis_tx_tready;

  always_comb begin
    pc      = 4'($countones(s_axis_tx_tkeep));
    len_sum = {1'b0, len_q} + {13'b0, pc};
    len_new = len_sum[16] ? 16'hFFFF : len_sum[15:0];
    case (s_axis_tx_tkeep)
      8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF: last_keep_ok = 1'b1;
      default:                                                last_keep_ok = 1'b0;
    endcase
    keep_err   = s_axis_tx_tlast ? !last_keep_ok : (s_axis_tx_tkeep != 8'hFF);
    frame_kerr = kerr_q | keep_err;
    runt       = len_new < 16'(MIN_FRAME);
    giant      = len_new > 16'(MAX_FRAME);
    bad        = frame_kerr | runt | giant | s_axis_tx_tuser;
  end

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    kerr_d      = kerr_q;
    frame_cnt_d = frame_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    err_cnt_d   = err_cnt_q;
    err_flags_d = err_flags_q;
    last_len_d  = last_len_q;
    done_d      = done_q;
    if (beat) begin
      if (s_axis_tx_tlast) begin
        state_d    = S_IDLE;
        len_d      = 16'd0;
        kerr_d     = 1'b0;
        last_len_d = len_new;
        if (bad) begin
          err_flags_d = err_flags_q | {s_axis_tx_tuser, giant, runt, frame_kerr};
          if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
        end else begin
          frame_cnt_d = frame_cnt_q + 32'd1;
          byte_cnt_d  = byte_cnt_q + {16'b0, len_new};
        end
      end else begin
        state_d = S_RECV;
        len_d   = len_new;
        kerr_d  = frame_kerr;
      end
    end
    // Terminal state is entered on the same edge that makes the frame total reach the limit.
    total_d = {1'b0, frame_cnt_d} + {17'b0, err_cnt_d};
    if (beat && s_axis_tx_tlast && total_d == 33'(MAX_RECVPKT)) begin
      state_d = S_DONE;
      done_d  = 1'b1;
    end
  end

  always_ff @(posedge clk156 or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      len_q       <= 16'd0;
      kerr_q      <= 1'b0;
      frame_cnt_q <= 32'd0;
      byte_cnt_q  <= 32'd0;
      err_cnt_q   <= 16'd0;
      err_flags_q <= 4'd0;
      last_len_q  <= 16'd0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      kerr_q      <= kerr_d;
      frame_cnt_q <= frame_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      err_cnt_q   <= err_cnt_d;
      err_flags_q <= err_flags_d;
      last_len_q  <= last_len_d;
      done_q      <= done_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign byte_cnt  = byte_cnt_q;
  assign err_cnt   = err_cnt_q;
  assign err_flags = err_flags_q;
  assign last_len  = last_len_q;
  assign done      = done_q;

endmodule

// File: tb/tb_axis_tx_sink.sv
// Randomized bench for axis_tx_sink: frames are byte-count driven, results predicted from framing rules.
module tb_axis_tx_sink;

  localparam int TB_MAX = 12;

  logic        clk156;
  logic        rst_n;
  logic        s_axis_tx_tvalid;
  logic [63:0] s_axis_tx_tdata;
  logic [7:0]  s_axis_tx_tkeep;
  logic        s_axis_tx_tlast;
  logic        s_axis_tx_tuser;
  logic        s_axis_tx_tready;
  logic [31:0] frame_cnt;
  logic [31:0] byte_cnt;
  logic [15:0] err_cnt;
  logic [3:0]  err_flags;
  logic [15:0] last_len;
  logic        done;

  axis_tx_sink #(.MAX_RECVPKT(TB_MAX)) dut (
    .clk156           (clk156),
    .rst_n            (rst_n),
    .s_axis_tx_tvalid (s_axis_tx_tvalid),
    .s_axis_tx_tdata  (s_axis_tx_tdata),
    .s_axis_tx_tkeep  (s_axis_tx_tkeep),
    .s_axis_tx_tlast  (s_axis_tx_tlast),
    .s_axis_tx_tuser  (s_axis_tx_tuser),
    .s_axis_tx_tready (s_axis_tx_tready),
    .frame_cnt        (frame_cnt),
    .byte_cnt         (byte_cnt),
    .err_cnt          (err_cnt),
    .err_flags        (err_flags),
    .last_len         (last_len),
    .done             (done)
  );

  initial clk156 = 1'b0;
  always #5 clk156 = ~clk156;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [7:0]  beat_keep[$];
  logic [31:0] exp_frame_cnt;
  logic [31:0] exp_byte_cnt;
  logic [15:0] exp_err_cnt;
  logic [3:0]  exp_err_flags;
  logic [15:0] exp_last_len;
  logic        exp_done;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_frame_cnt = 0;
    exp_byte_cnt  = 0;
    exp_err_cnt   = 0;
    exp_err_flags = 0;
    exp_last_len  = 0;
    exp_done      = 0;
  endtask

  task automatic build_frame(input int nbytes);
    int rem;
    beat_keep.delete();
    for (int i = 0; i < nbytes / 8; i++) beat_keep.push_back(8'hFF);
    rem = nbytes % 8;
    if (rem != 0) beat_keep.push_back(8'((1 << rem) - 1));
  endtask

  task automatic model_frame(input logic tuser);
    logic [7:0] legal[8];
    int         len;
    logic       kbad, ok, runt, giant;
    legal = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF};
    len  = 0;
    kbad = 1'b0;
    foreach (beat_keep[i]) begin
      len += $countones(beat_keep[i]);
      if (i < beat_keep.size() - 1 && beat_keep[i] != 8'hFF) kbad = 1'b1;
    end
    ok = 1'b0;
    foreach (legal[j]) if (beat_keep[beat_keep.size() - 1] == legal[j]) ok = 1'b1;
    if (!ok) kbad = 1'b1;
    if (len > 65535) len = 65535;
    runt  = len < 60;
    giant = len > 1514;
    exp_last_len = 16'(len);
    if (kbad || runt || giant || tuser) begin
      exp_err_flags |= {tuser, giant, runt, kbad};
      if (exp_err_cnt != 16'hFFFF) exp_err_cnt++;
    end else begin
      exp_frame_cnt++;
      exp_byte_cnt += 32'(len);
    end
    if (int'(exp_frame_cnt) + int'(exp_err_cnt) == TB_MAX) exp_done = 1'b1;
  endtask

  task automatic check_outputs(input string name);
    check_eq({name, ".frame_cnt"}, frame_cnt, exp_frame_cnt);
    check_eq({name, ".byte_cnt"},  byte_cnt,  exp_byte_cnt);
    check_eq({name, ".err_cnt"},   32'(err_cnt),   32'(exp_err_cnt));
    check_eq({name, ".err_flags"}, 32'(err_flags), 32'(exp_err_flags));
    check_eq({name, ".last_len"},  32'(last_len),  32'(exp_last_len));
    check_eq({name, ".done"},      32'(done),      32'(exp_done));
  endtask

  // Drives beat_keep with random idle gaps; stops after max_beats transfers or budget wasted cycles.
  task automatic drive_frame(input logic tuser, input int max_beats, input int budget, output int taken);
    int   n, i, stalls;
    logic rdy;
    n = beat_keep.size();
    if (max_beats < n) n = max_beats;
    i = 0;
    stalls = 0;
    taken = 0;
    while (i < n && stalls < budget) begin
      @(negedge clk156);
      s_axis_tx_tdata = {$urandom, $urandom};
      if ($urandom_range(0, 5) == 0) begin
        s_axis_tx_tvalid = 1'b0;
        s_axis_tx_tkeep  = 8'($urandom);
        s_axis_tx_tlast  = 1'b0;
        s_axis_tx_tuser  = 1'b0;
        stalls++;
        @(posedge clk156);
      end else begin
        s_axis_tx_tvalid = 1'b1;
        s_axis_tx_tkeep  = beat_keep[i];
        s_axis_tx_tlast  = (i == beat_keep.size() - 1);
        s_axis_tx_tuser  = (i == beat_keep.size() - 1) ? tuser : 1'b0;
        rdy = s_axis_tx_tready;
        @(posedge clk156);
        if (rdy) begin
          i++;
          taken++;
        end else begin
          stalls++;
        end
      end
    end
    @(negedge clk156);
    s_axis_tx_tvalid = 1'b0;
    s_axis_tx_tlast  = 1'b0;
    s_axis_tx_tuser  = 1'b0;
  endtask

  task automatic run_frame(input string name, input logic tuser);
    int taken;
    drive_frame(tuser, 1 << 30, 4000, taken);
    check_eq({name, ".beats"}, taken, beat_keep.size());
    model_frame(tuser);
    check_outputs(name);
    $display("frame %s: %0d beats, last_len=%0d frame_cnt=%0d err_cnt=%0d flags=%b done=%b",
             name, taken, last_len, frame_cnt, err_cnt, err_flags, done);
  endtask

  task automatic do_reset(input string name);
    @(negedge clk156);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk156);
    check_outputs(name);
    check_eq({name, ".tready"}, 32'(s_axis_tx_tready), 32'd1);
    @(negedge clk156);
    rst_n = 1'b1;
  endtask

  initial begin
    #900us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int taken;
    int kind;
    rst_n            = 1'b1;
    s_axis_tx_tvalid = 1'b0;
    s_axis_tx_tdata  = '0;
    s_axis_tx_tkeep  = '0;
    s_axis_tx_tlast  = 1'b0;
    s_axis_tx_tuser  = 1'b0;
    model_reset();
    #2 rst_n = 1'b0;
    do_reset("reset");

    build_frame(64);  run_frame("good64", 1'b0);
    build_frame(61);  run_frame("good61", 1'b0);
    build_frame(61);  beat_keep[7] = 8'h05; run_frame("lastkeep05", 1'b0);
    build_frame(64);  beat_keep[3] = 8'h7F; run_frame("midkeep7F", 1'b0);
    build_frame(40);  run_frame("runt40", 1'b0);
    build_frame(1520); run_frame("giant1520", 1'b0);
    build_frame(64);  run_frame("tuser64", 1'b1);

    // Reset in the middle of a frame discards it entirely.
    build_frame(64);
    drive_frame(1'b0, 3, 4000, taken);
    check_eq("partial.beats", taken, 3);
    do_reset("midreset");
    build_frame(64);  run_frame("after_reset", 1'b0);

    do_reset("rand_reset");
    for (int f = 0; f < TB_MAX; f++) begin
      kind = $urandom_range(0, 5);
      case (kind)
        0: build_frame($urandom_range(1, 59));
        1: build_frame($urandom_range(1515, 1600));
        default: build_frame($urandom_range(60, 600));
      endcase
      if (kind == 2 && beat_keep.size() > 1)
        beat_keep[$urandom_range(0, beat_keep.size() - 2)] = 8'($urandom_range(0, 254));
      run_frame($sformatf("rand%0d", f), (kind == 3));
    end
    check_eq("done.tready", 32'(s_axis_tx_tready), 32'd0);

    // Once done, nothing further is accepted.
    build_frame(64);
    drive_frame(1'b0, 1 << 30, 20, taken);
    check_eq("after_done.beats", taken, 0);
    check_outputs("after_done");
    $display("after done: %0d beats taken, tready=%b", taken, s_axis_tx_tready);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
